data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-requester arbiter and sequencer placed in front of the single-ported `data_memory` block. It shares the memory between requester 0 (CPU MEM stage) and requester 1 (debug/loader port). It accepts one request at a time with round-robin fairness, drives the memory control strobes for exactly one cycle, and returns read data or write completion through a registered response. It also rejects out-of-range addresses without touching memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte/word address width, passed unchanged to memory.
- `DATA_WIDTH`, default 32: data width.
- `MEM_WORDS`, default 256: addresses `>= MEM_WORDS` are out of range.

Ports:
- `clock_in` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `reqValid0` / `reqValid1` in 1: request present.
- `reqWrite0` / `reqWrite1` in 1: 1 = write, 0 = read.
- `reqAddr0` / `reqAddr1` in ADDR_WIDTH: request address.
- `reqWData0` / `reqWData1` in DATA_WIDTH: write data.
- `reqReady0` / `reqReady1` out 1: request accepted this cycle (combinational).
- `rspValid0` / `rspValid1` out 1: one-cycle completion pulse.
- `rspData0` / `rspData1` out DATA_WIDTH: read data, held until next response to that port.
- `rspErr0` / `rspErr1` out 1: completion was out of range; valid with `rspValid`.
- `memWrite`, `memRead` out 1: memory strobes.
- `address` out ADDR_WIDTH: memory address.
- `writeData` out DATA_WIDTH: memory write data.
- `readData` in DATA_WIDTH: memory read data, combinational from `address`/`memRead`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **Arbitration (IDLE or RESP):**
  - Winner is the sole valid requester.
  - If both are valid, the winner is the port not equal to `lastGrant`.
  - `reqReady` of the winner = 1 and the loser = 0, combinationally.
  - On the edge, latch write/addr/wdata/port into command registers, set `lastGrant` = winner, and go to ACCESS.
  - With no valid request: IDLE stays in IDLE; RESP goes to IDLE.
- **ACCESS:**
  - Drive `address`/`writeData` from command registers.
  - In range: `memRead` = !write, `memWrite` = write.
  - Out of range: both strobes 0.
  - On the edge: capture `readData` (read, in range) into the winner's `rspData`, else leave `rspData` unchanged. Set `rspErr` for the winner, then go to RESP.
- **RESP:** `rspValid` of the latched port = 1 for this cycle only. Arbitration proceeds in the same cycle, giving back-to-back operation.
- **Requester rules:**
  - Hold `req*` fields stable while `reqValid` = 1 and `reqReady` = 0.
  - Withdrawing `reqValid` before `reqReady` is legal and has no effect.
  - `reqReady` is never asserted in ACCESS.
- **Reset values:**
  - State = IDLE, `lastGrant` = 1, so port 0 wins the first tie.
  - All strobes, ready, rspValid and rspErr = 0. rspData = 0. address/writeData = 0.
- **Reset mid-operation:** strobes drop asynchronously, so a write in ACCESS is suppressed. The in-flight transaction is discarded and no `rspValid` is issued.
- **Out of range:** the write is dropped, the read returns `rspData` unchanged, and `rspErr` = 1.

## Timing
- Request accepted in cycle N (IDLE or RESP).
- Memory access in N+1.
- `rspValid` in N+2.
- Peak throughput: one transaction per 2 cycles; total latency 2 cycles.
- Both ports continuously valid: grants alternate 0,1,0,1 starting with 0 after reset.
- The memory write commits at the rising edge ending ACCESS.
- The read sample uses `readData` settled during ACCESS.
- `rspValid` never asserts to both ports in the same cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - port index constants `PORT_CPU`=0 and `PORT_DBG`=1.
- One sub-module `rr_arbiter2`: combinational winner select from (valid0, valid1, lastGrant) → (grant, anyValid).
- The top holds the FSM, command registers and response registers.

## Test plan
- **Port 0 single read:** preload mem[0x0F]=3; port 0 read 0x0F. `reqReady0` in cycle N, `memRead`=1 at N+1, `rspValid0` at N+2 with `rspData0`=3 and `rspErr0`=0.
- **Port 1 write then read:** write 0xDEADBEEF to 0x10, then read 0x10 → `memWrite` pulses exactly once; the read returns 0xDEADBEEF on `rspData1`.
- **Contention:** both ports continuously request reads of different addresses for 8 transactions → grants strictly alternate 0,1,0,…, with a `rspValid` every 2 cycles.
- **Out of range:** port 0 writes address `MEM_WORDS` (256) → `memWrite` stays 0, and `rspValid0`=1 with `rspErr0`=1.
- **Reset mid-write:** assert `reset_n`=0 during ACCESS of a write to 0x05 → `memWrite` drops immediately, mem[0x05] is unchanged, no `rspValid`, and all outputs are at reset values.
- **Withdrawn request:** port 1 raises `reqValid1` while ACCESS is in progress, then drops it before RESP → no grant and no memory strobe for port 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select; a tie goes to the port that did not win last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any_valid
);

  always_comb begin
    any_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else if (valid1) begin
      grant = PORT_DBG;
    end else begin
      grant = PORT_CPU;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-ported data memory between the CPU MEM stage and a debug/loader port.
// One transaction at a time: accept, one-cycle memory access, one-cycle response pulse.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 256
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  reqValid0,
  input  logic                  reqValid1,
  input  logic                  reqWrite0,
  input  logic                  reqWrite1,
  input  logic [ADDR_WIDTH-1:0] reqAddr0,
  input  logic [ADDR_WIDTH-1:0] reqAddr1,
  input  logic [DATA_WIDTH-1:0] reqWData0,
  input  logic [DATA_WIDTH-1:0] reqWData1,
  output logic                  reqReady0,
  output logic                  reqReady1,
  output logic                  rspValid0,
  output logic                  rspValid1,
  output logic [DATA_WIDTH-1:0] rspData0,
  output logic [DATA_WIDTH-1:0] rspData1,
  output logic                  rspErr0,
  output logic                  rspErr1,
  output logic                  memWrite,
  output logic                  memRead,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic [DATA_WIDTH-1:0] readData
);

  arb_state_e            state_q;
  logic                  last_grant_q;
  logic                  cmd_write_q;
  logic                  cmd_in_range_q;
  logic                  cmd_port_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [1:0]            rsp_valid_q;
  logic [1:0]            rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_data0_q;
  logic [DATA_WIDTH-1:0] rsp_data1_q;

  logic                  grant;
  logic                  any_valid;
  logic                  arb_open;
  logic                  accept;
  logic                  sel_write;
  logic                  sel_in_range;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .valid0     (reqValid0),
    .valid1     (reqValid1),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  assign arb_open  = (state_q == IDLE) || (state_q == RESP);
  assign accept    = arb_open && any_valid;
  assign reqReady0 = arb_open && reqValid0 && (grant == PORT_CPU);
  assign reqReady1 = arb_open && reqValid1 && (grant == PORT_DBG);

  always_comb begin
    sel_write = (grant == PORT_DBG) ? reqWrite1 : reqWrite0;
    sel_addr  = (grant == PORT_DBG) ? reqAddr1  : reqAddr0;
    sel_wdata = (grant == PORT_DBG) ? reqWData1 : reqWData0;
    // Range check decided at acceptance so ACCESS strobes come straight from flops.
    sel_in_range = (64'(sel_addr) < 64'(MEM_WORDS));
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_grant_q   <= PORT_DBG;
      cmd_write_q    <= 1'b0;
      cmd_in_range_q <= 1'b0;
      cmd_port_q     <= PORT_CPU;
      cmd_addr_q     <= '0;
      cmd_wdata_q    <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_err_q      <= '0;
      rsp_data0_q    <= '0;
      rsp_data1_q    <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            state_q        <= ACCESS;
            last_grant_q   <= grant;
            cmd_port_q     <= grant;
            cmd_write_q    <= sel_write;
            cmd_in_range_q <= sel_in_range;
            cmd_addr_q     <= sel_addr;
            cmd_wdata_q    <= sel_wdata;
            mem_read_q     <= sel_in_range && !sel_write;
            mem_write_q    <= sel_in_range && sel_write;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q                 <= RESP;
          rsp_valid_q[cmd_port_q] <= 1'b1;
          rsp_err_q[cmd_port_q]   <= !cmd_in_range_q;
          if (cmd_in_range_q && !cmd_write_q) begin
            if (cmd_port_q == PORT_DBG) begin
              rsp_data1_q <= readData;
            end else begin
              rsp_data0_q <= readData;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memRead   = mem_read_q;
  assign memWrite  = mem_write_q;
  assign address   = cmd_addr_q;
  assign writeData = cmd_wdata_q;
  assign rspValid0 = rsp_valid_q[0];
  assign rspValid1 = rsp_valid_q[1];
  assign rspErr0   = rsp_err_q[0];
  assign rspErr1   = rsp_err_q[1];
  assign rspData0  = rsp_data0_q;
  assign rspData1  = rsp_data1_q;

endmodule
